// File: rtl/sram_controller.sv
// sram_controller: sequences a 16-bit asynchronous SRAM for the cache controller.
// Word writes are split into two half-word writes. Block reads are gathered from
// four half-word reads. A one-cycle ready pulse marks completion of each request.
module sram_controller #(
    parameter int ADDR_OFFSET   = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [63:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cyc_reg, cyc_next;
    logic [1:0]      phase_reg, phase_next;
    logic [17:0]     haddr_reg;
    logic [31:0]     wdata_reg;
    logic            is_read_reg;
    logic            rd_block_reg;

    logic [31:0]     eff;
    logic            phase_end;
    logic            last_phase;
    logic            accept_wr;
    logic            accept_rd;
    logic            dq_oe;
    logic [15:0]     dq_out;
    logic [15:0]     half_q [4];
    logic            unused_bits;

    // Byte address relative to the SRAM window; only the half-word index bits matter.
    assign eff         = address - 32'(ADDR_OFFSET);
    assign unused_bits = &{1'b0, eff[31:19], eff[0]};

    assign phase_end  = (cyc_reg == CW'(ACCESS_CYCLES - 1));
    assign last_phase = (state_reg == WR) ? (phase_reg == 2'd1) : (phase_reg == 2'd3);

    // A write always wins. A read is refused while the read_en level that belongs to
    // the block just delivered is still high, so a held read_en cannot retrigger.
    assign accept_wr = (state_reg == IDLE) && write_en;
    assign accept_rd = (state_reg == IDLE) && !write_en && read_en && !rd_block_reg;

    // State register with phase and cycle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            phase_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state logic: each phase lasts ACCESS_CYCLES cycles, DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        phase_next = phase_reg;
        case (state_reg)
            IDLE: begin
                cyc_next   = '0;
                phase_next = 2'd0;
                if (accept_wr)      state_next = WR;
                else if (accept_rd) state_next = RD;
            end
            WR, RD: begin
                if (phase_end) begin
                    cyc_next = '0;
                    if (last_phase) state_next = DONE;
                    else            phase_next = phase_reg + 2'd1;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = '0;
                phase_next = 2'd0;
            end
        endcase
    end

    // Output decode: SRAM controls, address and bus direction follow state and phase.
    always_comb begin
        ready     = 1'b0;
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        case (state_reg)
            WR: begin
                SRAM_ADDR = {haddr_reg[17:1], phase_reg[0]};
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                dq_oe     = 1'b1;
            end
            RD: begin
                SRAM_ADDR = {haddr_reg[17:2], phase_reg};
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    assign dq_out  = phase_reg[0] ? wdata_reg[31:16] : wdata_reg[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

    // Request capture: address and write data are frozen at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haddr_reg   <= 18'd0;
            wdata_reg   <= 32'd0;
            is_read_reg <= 1'b0;
        end else if (accept_wr) begin
            haddr_reg   <= eff[18:1];
            wdata_reg   <= write_data;
            is_read_reg <= 1'b0;
        end else if (accept_rd) begin
            haddr_reg   <= eff[18:1];
            is_read_reg <= 1'b1;
        end
    end

    // Read retrigger guard: armed when a read finishes with read_en still high,
    // released as soon as read_en is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_block_reg <= 1'b0;
        else if (state_reg == DONE && is_read_reg && read_en)
            rd_block_reg <= 1'b1;
        else if (!read_en)
            rd_block_reg <= 1'b0;
    end

    // One capture lane per half-word of the block, loaded on the edge ending its phase.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] half_reg;
            // Sample the SRAM bus at the end of read phase gi.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    half_reg <= 16'd0;
                else if (state_reg == RD && phase_end && phase_reg == 2'(gi))
                    half_reg <= SRAM_DQ;
            end
            assign half_q[gi] = half_reg;
        end
    endgenerate

    assign read_data = {half_q[3], half_q[2], half_q[1], half_q[0]};

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller against a small SRAM model.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [63:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    int checks = 0;
    int errors = 0;

    // SRAM model storage plus a preload port used only while the controller is idle.
    logic [15:0] mem [0:63];
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = 6'd0;
    logic [15:0] load_val = 16'd0;

    always #5 clk = ~clk;

    sram_controller #(.ADDR_OFFSET(1024), .ACCESS_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .read_en    (read_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    // SRAM model: drives the bus while output-enabled, stores on each write-enabled clock.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'bz;

    always @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_val;
        else if (!sram_ce_n && !sram_we_n)
            mem[sram_addr[5:0]] <= sram_dq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [15:0] v);
        load_addr = a;
        load_val  = v;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] ea;

        // Reset held, then released: controls idle for 10 cycles with no requests.
        tick(); tick(); tick();
        check("rst_ctrl", {59'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 64'h1f);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_rdata", read_data, 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("idle_ctrl_c%0d", c),
                  {40'd0, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, ready},
                  {40'd0, 18'd0, 5'b11111, 1'b0});
        end

        // Word write 0xDEADBEEF at 1024+0x10 -> half-words 0x08 and 0x09.
        write_en = 1'b1; address = 32'd1024 + 32'h10; write_data = 32'hDEADBEEF;
        tick();
        write_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            ea = (c <= 2) ? 8'h08 : (c <= 4) ? 8'h09 : 8'h00;
            check($sformatf("wr_we_n_c%0d", c), {63'd0, sram_we_n}, {63'd0, (c > 4)});
            check($sformatf("wr_ready_c%0d", c), {63'd0, ready}, {63'd0, (c == 5)});
            check($sformatf("wr_addr_c%0d", c), {46'd0, sram_addr}, {56'd0, ea});
            tick();
        end
        check("wr_mem08", {48'd0, mem[8]}, 64'h0000_0000_0000_BEEF);
        check("wr_mem09", {48'd0, mem[9]}, 64'h0000_0000_0000_DEAD);
        check("wr_rdata_kept", read_data, 64'd0);

        // Block read at 1024+0x14 -> half-words 0x08..0x0B; read_en held 3 cycles past ready.
        load(6'h08, 16'h1111); load(6'h09, 16'h2222); load(6'h0A, 16'h3333); load(6'h0B, 16'h4444);
        read_en = 1'b1; address = 32'd1024 + 32'h14;
        tick();
        address = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            ea = (c <= 8) ? (8'h08 + 8'((c - 1) / 2)) : 8'h00;
            check($sformatf("rd_addr_c%0d", c), {46'd0, sram_addr}, {56'd0, ea});
            check($sformatf("rd_oe_n_c%0d", c), {62'd0, sram_oe_n, sram_we_n}, {62'd0, (c > 8), 1'b1});
            check($sformatf("rd_ready_c%0d", c), {63'd0, ready}, {63'd0, (c == 9)});
            if (c == 9) check("rd_data", read_data, 64'h4444_3333_2222_1111);
            tick();
        end
        read_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rd_quiet_c%0d", c), {62'd0, sram_oe_n, ready}, {62'd0, 1'b1, 1'b0});
            tick();
        end

        // Write and read together at 1024+0x20: write first, read follows after DONE.
        load(6'h12, 16'hAAAA); load(6'h13, 16'hBBBB);
        write_en = 1'b1; read_en = 1'b1; address = 32'd1024 + 32'h20; write_data = 32'h1234_5678;
        tick();
        write_en = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c <= 4)                ea = 8'h10 + 8'((c - 1) / 2);
            else if (c >= 7 && c <= 14) ea = 8'h10 + 8'((c - 7) / 2);
            else                       ea = 8'h00;
            check($sformatf("both_addr_c%0d", c), {46'd0, sram_addr}, {56'd0, ea});
            check($sformatf("both_ctl_c%0d", c), {61'd0, sram_we_n, sram_oe_n, ready},
                  {61'd0, (c > 4), !(c >= 7 && c <= 14), (c == 5 || c == 15)});
            if (c == 5)  check("both_rdata_kept", read_data, 64'h4444_3333_2222_1111);
            if (c == 15) begin
                check("both_rdata", read_data, 64'hBBBB_AAAA_1234_5678);
                read_en = 1'b0;
            end
            tick();
        end
        check("both_mem10", {48'd0, mem[16]}, 64'h5678);
        check("both_mem11", {48'd0, mem[17]}, 64'h1234);

        // Reset during read phase 2: controls drop at once, no ready, then a clean read.
        read_en = 1'b1; address = 32'd1024 + 32'h14;
        tick(); tick(); tick(); tick(); tick();
        check("mid_addr", {46'd0, sram_addr, sram_oe_n}, {46'd0, 18'h0A, 1'b0});
        rst = 1'b1;
        #1;
        check("mid_ctrl", {40'd0, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, ready},
              {40'd0, 18'd0, 5'b11111, 1'b0});
        check("mid_rdata", read_data, 64'd0);
        read_en = 1'b0;
        tick();
        check("mid_noready0", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        tick();
        check("mid_noready1", {63'd0, ready}, 64'd0);
        load(6'h08, 16'h5555); load(6'h09, 16'h6666); load(6'h0A, 16'h7777); load(6'h0B, 16'h8888);
        read_en = 1'b1; address = 32'd1024 + 32'h14;
        tick();
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("post_ready_c%0d", c), {63'd0, ready}, {63'd0, (c == 9)});
            if (c == 9) begin
                check("post_rdata", read_data, 64'h8888_7777_6666_5555);
                read_en = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
